rc4_arb_ctrl: RTL

RC4_ARB_CTRL -- requirements
Module: rc4_arb_ctrl

---
 rtl/rc4_pkg.sv | 19 +
 rtl/rc4_out_reg.sv | 37 +++
 rtl/rc4_arb_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared FSM encoding, key-length limit and helpers
// for the rc4 two-channel session arbiter.
package rc4_pkg;

  localparam int KEY_MAX_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_KEY,
    S_STREAM,
    S_FIN
  } state_t;

  function automatic logic [1:0] ch_onehot(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rc4_out_reg.sv
// rc4_out_reg: 1-entry valid/ready output register with flush.
// Ports: load/d_in/last_in/ch_in in, ready in, valid/data/last/ch out.
module rc4_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       flush,
  input  logic [7:0] d_in,
  input  logic       last_in,
  input  logic       ch_in,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       last,
  output logic       ch
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
      ch    <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_in;
      last  <= last_in;
      ch    <= ch_in;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rc4_arb_ctrl.sv
// rc4_arb_ctrl: round-robin 2-channel session arbiter driving an rc4
// core; req/key/len per channel in, gnt/done/err, din/dout, core_* out.
module rc4_arb_ctrl
  import rc4_pkg::*;
#(
  parameter int MSG_W   = 16,
  parameter int KEY_MAX = KEY_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [31:0]      key0,
  input  logic [31:0]      key1,
  input  logic [7:0]       key_len0,
  input  logic [7:0]       key_len1,
  input  logic [MSG_W-1:0] msg_len0,
  input  logic [MSG_W-1:0] msg_len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [7:0]       din,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [7:0]       dout,
  output logic             dout_ch,
  output logic             dout_last,
  output logic             core_start,
  output logic [31:0]      core_key,
  output logic [7:0]       core_key_len,
  output logic             core_abort,
  input  logic             core_ks_valid,
  input  logic [7:0]       core_ks,
  output logic             core_ks_ready
);

  localparam logic [7:0] KMAX = 8'(KEY_MAX);

  state_t state, state_d;

  logic             ch_q;
  logic             prio_q;
  logic             win;
  logic [MSG_W-1:0] cnt_q;
  logic [MSG_W-1:0] len_q;
  logic [7:0]       win_klen;
  logic [MSG_W-1:0] win_mlen;
  logic             any_req;
  logic             key_bad;
  logic             len_zero;
  logic             req_g;
  logic             is_last;
  logic             xfer;
  logic             grant;
  logic             reject;
  logic             zero;
  logic             abort;
  logic             finish;

  // Ties go to prio_q, the channel not served last.
  always_comb begin
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = prio_q;
    endcase
  end

  assign win_klen = win ? key_len1 : key_len0;
  assign win_mlen = win ? msg_len1 : msg_len0;
  assign any_req  = |req;
  assign key_bad  = (win_klen == 8'd0) || (win_klen > KMAX);
  assign len_zero = (win_mlen == '0);
  assign req_g    = req[ch_q];
  assign is_last  = (cnt_q == len_q - 1'b1);

  // Plaintext and keystream move together or not at all.
  assign xfer = (state == S_STREAM) && req_g && din_valid
              && core_ks_valid && (!dout_valid || dout_ready);

  assign din_ready     = xfer;
  assign core_ks_ready = xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    grant   = 1'b0;
    reject  = 1'b0;
    zero    = 1'b0;
    abort   = 1'b0;
    finish  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_req && !(|done) && !(|err))
          state_d = S_ARB;
      end
      S_ARB: begin
        unique case (1'b1)
          !any_req: state_d = S_IDLE;
          any_req && key_bad: begin
            reject  = 1'b1;
            state_d = S_IDLE;
          end
          any_req && !key_bad && len_zero: begin
            zero    = 1'b1;
            state_d = S_IDLE;
          end
          any_req && !key_bad && !len_zero: begin
            grant   = 1'b1;
            state_d = S_KEY;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_KEY: begin
        if (!req_g) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (core_ks_valid) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (!req_g) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (xfer && is_last) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        // Only the last byte can be resident here.
        if (!dout_valid || dout_ready) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= '0;
      done         <= '0;
      err          <= '0;
      core_start   <= 1'b0;
      core_abort   <= 1'b0;
      core_key     <= '0;
      core_key_len <= '0;
      ch_q         <= 1'b0;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
    end else begin
      done       <= '0;
      err        <= '0;
      core_start <= 1'b0;
      core_abort <= 1'b0;
      if (reject) begin
        err    <= ch_onehot(win);
        prio_q <= ~win;
      end
      if (zero) begin
        done   <= ch_onehot(win);
        prio_q <= ~win;
      end
      if (grant) begin
        gnt          <= ch_onehot(win);
        ch_q         <= win;
        prio_q       <= ~win;
        core_start   <= 1'b1;
        core_key     <= win ? key1 : key0;
        core_key_len <= win_klen;
        cnt_q        <= '0;
        len_q        <= win_mlen;
      end
      if (xfer) cnt_q <= cnt_q + 1'b1;
      if (abort) begin
        core_abort <= 1'b1;
        gnt        <= '0;
      end
      if (finish) begin
        done <= ch_onehot(ch_q);
        gnt  <= '0;
      end
    end
  end

  rc4_out_reg u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (xfer),
    .flush   (abort),
    .d_in    (din ^ core_ks),
    .last_in (is_last),
    .ch_in   (ch_q),
    .ready   (dout_ready),
    .valid   (dout_valid),
    .data    (dout),
    .last    (dout_last),
    .ch      (dout_ch)
  );

endmodule
